// File: rtl/iobuf_pkg.sv
// Shared types and parameter limits for the registered bidirectional pad-bus port.
// Imported by iobuf_sync and iobuf_bus_port.
package iobuf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_DRIVE = 1'b1
  } dir_t;

  localparam int MAX_WIDTH = 32;
  localparam int MAX_TURN  = 15;
  localparam int MAX_SYNC  = 4;

  function automatic bit params_ok(input int width, input int turn, input int sync);
    return (width >= 1) && (width <= MAX_WIDTH) &&
           (turn  >= 1) && (turn  <= MAX_TURN)  &&
           (sync  >= 1) && (sync  <= MAX_SYNC);
  endfunction

endpackage

// File: rtl/iobuf_sync.sv
// Async-reset flop chain that brings the external pad value into the clock domain.
// Output is the last stage; depth sets the read-sample wait in the top.
module iobuf_sync
  import iobuf_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [SYNC_STAGES];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/iobuf_bus_port.sv
// Registered bidirectional pad-bus port: direction FSM with hi-Z turnaround,
// req/ack write and read handshakes, synchronised pad sampling.
module iobuf_bus_port
  import iobuf_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wr_req,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_wr_ack,
  input  logic             i_rd_req,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  output logic [WIDTH-1:0] o_pad_in_sync,
  output logic             o_oe,
  output logic             o_busy,
  inout  wire  [WIDTH-1:0] io_pad
);

  if (!params_ok(WIDTH, TURN_CYCLES, SYNC_STAGES)) begin : g_param_error
    $error("iobuf_bus_port: WIDTH, TURN_CYCLES or SYNC_STAGES out of range");
  end

  localparam int TW = $clog2(TURN_CYCLES + 1);
  localparam int SW = $clog2(SYNC_STAGES + 1);
  localparam logic [TW-1:0] TURN_LAST   = TW'(TURN_CYCLES - 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SYNC_STAGES - 1);

  state_t           r_state, w_state;
  dir_t             r_dir,   w_dir;
  logic [WIDTH-1:0] r_out,   w_out;
  logic             r_oe,    w_oe;
  logic             r_wr_ack, w_wr_ack;
  logic             r_rd_valid, w_rd_valid;
  logic [WIDTH-1:0] r_rd_data, w_rd_data;
  logic [TW-1:0]    r_tcnt,  w_tcnt;
  logic [SW-1:0]    r_scnt,  w_scnt;
  logic [WIDTH-1:0] w_pad_sync;

  iobuf_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (io_pad),
    .o_q     (w_pad_sync)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_dir      <= DIR_READ;
      r_out      <= '0;
      r_oe       <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_tcnt     <= '0;
      r_scnt     <= '0;
    end else begin
      r_state    <= w_state;
      r_dir      <= w_dir;
      r_out      <= w_out;
      r_oe       <= w_oe;
      r_wr_ack   <= w_wr_ack;
      r_rd_valid <= w_rd_valid;
      r_rd_data  <= w_rd_data;
      r_tcnt     <= w_tcnt;
      r_scnt     <= w_scnt;
    end
  end

  // Write always beats read; a pending read is picked up once the write traffic stops.
  always_comb begin
    w_state    = r_state;
    w_dir      = r_dir;
    w_out      = r_out;
    w_oe       = r_oe;
    w_wr_ack   = 1'b0;
    w_rd_valid = 1'b0;
    w_rd_data  = r_rd_data;
    w_tcnt     = r_tcnt;
    w_scnt     = r_scnt;
    case (r_state)
      ST_IDLE: begin
        w_oe = 1'b0;
        if (i_wr_req) begin
          w_out    = i_wr_data;
          w_oe     = 1'b1;
          w_wr_ack = 1'b1;
          w_state  = ST_DRIVE;
        end else if (i_rd_req) begin
          w_scnt  = '0;
          w_state = ST_READ;
        end
      end
      ST_DRIVE: begin
        if (i_wr_req) begin
          w_out    = i_wr_data;
          w_wr_ack = 1'b1;
        end else if (i_rd_req) begin
          w_oe    = 1'b0;
          w_dir   = DIR_READ;
          w_tcnt  = '0;
          w_state = ST_TURN;
        end
      end
      ST_TURN: begin
        w_oe = 1'b0;
        if (r_tcnt == TURN_LAST) begin
          if (r_dir == DIR_DRIVE) begin
            if (i_wr_req) begin
              w_out    = i_wr_data;
              w_oe     = 1'b1;
              w_wr_ack = 1'b1;
              w_state  = ST_DRIVE;
            end else begin
              w_state = ST_IDLE;
            end
          end else begin
            w_scnt  = '0;
            w_state = ST_READ;
          end
        end else begin
          w_tcnt = r_tcnt + 1'b1;
        end
      end
      ST_READ: begin
        w_oe = 1'b0;
        if (i_wr_req) begin
          w_dir   = DIR_DRIVE;
          w_tcnt  = '0;
          w_state = ST_TURN;
        end else if (!r_rd_valid) begin
          // The rd_valid cycle itself is not counted, giving one beat per SYNC_STAGES+1 cycles.
          if (r_scnt == SAMPLE_LAST) begin
            w_rd_data  = w_pad_sync;
            w_rd_valid = 1'b1;
            w_scnt     = '0;
          end else begin
            w_scnt = r_scnt + 1'b1;
          end
        end else if (!i_rd_req) begin
          w_state = ST_IDLE;
        end
      end
      default: begin
        w_oe    = 1'b0;
        w_state = ST_IDLE;
      end
    endcase
  end

  assign o_wr_ack      = r_wr_ack;
  assign o_rd_valid    = r_rd_valid;
  assign o_rd_data     = r_rd_data;
  assign o_pad_in_sync = w_pad_sync;
  assign o_oe          = r_oe;
  assign o_busy        = (r_state == ST_TURN) | (i_wr_req & ~r_wr_ack) | (i_rd_req & ~r_rd_valid);
  assign io_pad        = r_oe ? r_out : {WIDTH{1'bz}};

endmodule

// File: tb/tb_iobuf_bus_port.sv
// Directed bench for iobuf_bus_port: main instance (8 bit, 2 turn, 2 sync) plus
// WIDTH=1/SYNC=1 and WIDTH=32/SYNC=4 instances for the latency formulas.
module tb_iobuf_bus_port;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // Main instance: WIDTH=8, TURN_CYCLES=2, SYNC_STAGES=2
   logic       wrReq, rdReq, wrAck, rdValid, oe, busy;
   logic [7:0] wrData, rdData, padSync;
   wire  [7:0] pad;
   logic       extEn;
   logic [7:0] extVal;
   assign pad = extEn ? extVal : 8'bz;

   // Narrow instance: WIDTH=1, TURN_CYCLES=1, SYNC_STAGES=1
   logic wrReq1, rdReq1, wrAck1, rdValid1, oe1, busy1;
   logic wrData1, rdData1, padSync1;
   wire  pad1;
   logic ext1En, ext1Val;
   assign pad1 = ext1En ? ext1Val : 1'bz;

   // Wide instance: WIDTH=32, TURN_CYCLES=3, SYNC_STAGES=4
   logic        wrReq32, rdReq32, wrAck32, rdValid32, oe32, busy32;
   logic [31:0] wrData32, rdData32, padSync32;
   wire  [31:0] pad32;
   logic        ext32En;
   logic [31:0] ext32Val;
   assign pad32 = ext32En ? ext32Val : 32'bz;

   int nCompared = 0;
   int nMismatched = 0;
   int overlaps = 0;

   iobuf_bus_port #(.WIDTH(8), .TURN_CYCLES(2), .SYNC_STAGES(2)) u_dut (
      .i_clk(clk), .i_reset(rst), .i_wr_req(wrReq), .i_wr_data(wrData), .o_wr_ack(wrAck),
      .i_rd_req(rdReq), .o_rd_data(rdData), .o_rd_valid(rdValid), .o_pad_in_sync(padSync),
      .o_oe(oe), .o_busy(busy), .io_pad(pad));

   iobuf_bus_port #(.WIDTH(1), .TURN_CYCLES(1), .SYNC_STAGES(1)) u_w1 (
      .i_clk(clk), .i_reset(rst), .i_wr_req(wrReq1), .i_wr_data(wrData1), .o_wr_ack(wrAck1),
      .i_rd_req(rdReq1), .o_rd_data(rdData1), .o_rd_valid(rdValid1), .o_pad_in_sync(padSync1),
      .o_oe(oe1), .o_busy(busy1), .io_pad(pad1));

   iobuf_bus_port #(.WIDTH(32), .TURN_CYCLES(3), .SYNC_STAGES(4)) u_w32 (
      .i_clk(clk), .i_reset(rst), .i_wr_req(wrReq32), .i_wr_data(wrData32), .o_wr_ack(wrAck32),
      .i_rd_req(rdReq32), .o_rd_data(rdData32), .o_rd_valid(rdValid32), .o_pad_in_sync(padSync32),
      .o_oe(oe32), .o_busy(busy32), .io_pad(pad32));

   // Counts every cycle in which the port and the external device drive the bus together.
   always @(negedge clk) begin
      if (oe === 1'b1 && extEn) overlaps++;
   end

   // Advance to just after the next rising edge, where outputs are sampled and inputs change.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Async reset asserted mid-DRIVE must release the bus without waiting for a clock.
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      nCompared++; if (oe !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_init_oe: got %b want 0", oe); end
      nCompared++; if (rdData !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_init_rd_data: got %h want 00", rdData); end
      wrReq = 1'b1; wrData = 8'h77;
      tick();
      wrReq = 1'b0;
      nCompared++; if (oe !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_pre_oe: got %b want 1", oe); end
      nCompared++; if (pad !== 8'h77) begin nMismatched++; $display("[TB] FAIL reset_pre_pad: got %h want 77", pad); end
      #3;
      rst = 1'b1;
      #1;
      nCompared++; if (oe !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_async_oe: got %b want 0", oe); end
      nCompared++; if (wrAck !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_async_wr_ack: got %b want 0", wrAck); end
      nCompared++; if (rdValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_async_rd_valid: got %b want 0", rdValid); end
      nCompared++; if (padSync !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_async_pad_sync: got %h want 00", padSync); end
      nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_async_busy: got %b want 0", busy); end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_writes();
      wrReq = 1'b1; wrData = 8'hA5;
      tick();
      nCompared++; if (wrAck !== 1'b1) begin nMismatched++; $display("[TB] FAIL write1_ack: got %b want 1", wrAck); end
      nCompared++; if (pad !== 8'hA5) begin nMismatched++; $display("[TB] FAIL write1_pad: got %h want a5", pad); end
      wrData = 8'h5A;
      tick();
      nCompared++; if (wrAck !== 1'b1) begin nMismatched++; $display("[TB] FAIL write2_ack: got %b want 1", wrAck); end
      nCompared++; if (pad !== 8'h5A) begin nMismatched++; $display("[TB] FAIL write2_pad: got %h want 5a", pad); end
      wrData = 8'hFF;
      tick();
      nCompared++; if (wrAck !== 1'b1) begin nMismatched++; $display("[TB] FAIL write3_ack: got %b want 1", wrAck); end
      nCompared++; if (pad !== 8'hFF) begin nMismatched++; $display("[TB] FAIL write3_pad: got %h want ff", pad); end
      wrReq = 1'b0;
      tick();
      nCompared++; if (wrAck !== 1'b0) begin nMismatched++; $display("[TB] FAIL write_park_ack: got %b want 0", wrAck); end
      nCompared++; if (oe !== 1'b1 || pad !== 8'hFF) begin nMismatched++; $display("[TB] FAIL write_park_pad: got oe=%b pad=%h want oe=1 pad=ff", oe, pad); end
   endtask

   // DRIVE -> read: 2 hi-Z turn cycles, rd_valid after TURN+SYNC+1 = 5 cycles, then a back-to-back beat.
   task automatic test_write_read();
      int n;
      rdReq = 1'b1;
      tick(); n = 1;
      nCompared++; if (oe !== 1'b0 || busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL wr2rd_turn1: got oe=%b busy=%b want oe=0 busy=1", oe, busy); end
      extEn = 1'b1; extVal = 8'h3C;
      tick(); n = 2;
      nCompared++; if (oe !== 1'b0) begin nMismatched++; $display("[TB] FAIL wr2rd_turn2_oe: got %b want 0", oe); end
      while (rdValid !== 1'b1 && n < 30) begin tick(); n++; end
      nCompared++; if (n !== 5) begin nMismatched++; $display("[TB] FAIL wr2rd_latency: got %0d want 5", n); end
      nCompared++; if (rdData !== 8'h3C) begin nMismatched++; $display("[TB] FAIL wr2rd_data: got %h want 3c", rdData); end
      extVal = 8'hC3;
      n = 0;
      tick(); n++;
      while (rdValid !== 1'b1 && n < 30) begin tick(); n++; end
      nCompared++; if (n !== 3) begin nMismatched++; $display("[TB] FAIL rd_b2b_period: got %0d want 3", n); end
      nCompared++; if (rdData !== 8'hC3) begin nMismatched++; $display("[TB] FAIL rd_b2b_data: got %h want c3", rdData); end
      rdReq = 1'b0;
      tick();
      nCompared++; if (rdValid !== 1'b0 || rdData !== 8'hC3) begin nMismatched++; $display("[TB] FAIL rd_hold: got valid=%b data=%h want valid=0 data=c3", rdValid, rdData); end
   endtask

   // IDLE read (SYNC+1 = 3 cycles), then write during READ: 2 hi-Z cycles, ack after TURN+1 = 3.
   task automatic test_read_write();
      int n;
      extVal = 8'h5D;
      rdReq = 1'b1;
      n = 0;
      tick(); n++;
      while (rdValid !== 1'b1 && n < 30) begin tick(); n++; end
      nCompared++; if (n !== 3) begin nMismatched++; $display("[TB] FAIL idle_rd_latency: got %0d want 3", n); end
      nCompared++; if (rdData !== 8'h5D) begin nMismatched++; $display("[TB] FAIL idle_rd_data: got %h want 5d", rdData); end
      rdReq = 1'b0; wrReq = 1'b1; wrData = 8'h96;
      tick(); n = 1;
      nCompared++; if (oe !== 1'b0 || busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL rd2wr_turn1: got oe=%b busy=%b want oe=0 busy=1", oe, busy); end
      extEn = 1'b0;
      tick(); n = 2;
      nCompared++; if (oe !== 1'b0 || wrAck !== 1'b0) begin nMismatched++; $display("[TB] FAIL rd2wr_turn2: got oe=%b ack=%b want oe=0 ack=0", oe, wrAck); end
      while (wrAck !== 1'b1 && n < 30) begin tick(); n++; end
      wrReq = 1'b0;
      nCompared++; if (n !== 3) begin nMismatched++; $display("[TB] FAIL rd2wr_latency: got %0d want 3", n); end
      nCompared++; if (oe !== 1'b1 || pad !== 8'h96) begin nMismatched++; $display("[TB] FAIL rd2wr_pad: got oe=%b pad=%h want oe=1 pad=96", oe, pad); end
      nCompared++; if (overlaps !== 0) begin nMismatched++; $display("[TB] FAIL bus_overlap: got %0d cycles want 0", overlaps); end
   endtask

   // Both requests in IDLE: write first (1 cycle), read follows via DRIVE->TURN (ready at cycle 6).
   task automatic test_simultaneous();
      int n;
      int acks;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      tick();
      wrReq = 1'b1; rdReq = 1'b1; wrData = 8'hE7;
      tick(); n = 1;
      nCompared++; if (wrAck !== 1'b1 || pad !== 8'hE7) begin nMismatched++; $display("[TB] FAIL simul_write: got ack=%b pad=%h want ack=1 pad=e7", wrAck, pad); end
      nCompared++; if (rdValid !== 1'b0 || busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL simul_read_pending: got valid=%b busy=%b want valid=0 busy=1", rdValid, busy); end
      acks = 1;
      wrReq = 1'b0;
      tick(); n = 2;
      if (wrAck === 1'b1) acks++;
      extEn = 1'b1; extVal = 8'h18;
      while (rdValid !== 1'b1 && n < 30) begin tick(); n++; if (wrAck === 1'b1) acks++; end
      rdReq = 1'b0;
      nCompared++; if (n !== 6) begin nMismatched++; $display("[TB] FAIL simul_rd_latency: got %0d want 6", n); end
      nCompared++; if (rdData !== 8'h18) begin nMismatched++; $display("[TB] FAIL simul_rd_data: got %h want 18", rdData); end
      nCompared++; if (acks !== 1) begin nMismatched++; $display("[TB] FAIL simul_ack_count: got %0d want 1", acks); end
      tick();
      extEn = 1'b0;
   endtask

   // WIDTH=1, TURN=1, SYNC=1: read IDLE 2, write READ 2, read DRIVE 3, write IDLE 1.
   task automatic test_params_w1();
      int n;
      ext1En = 1'b1; ext1Val = 1'b1; rdReq1 = 1'b1;
      n = 0; tick(); n++;
      while (rdValid1 !== 1'b1 && n < 30) begin tick(); n++; end
      nCompared++; if (n !== 2 || rdData1 !== 1'b1) begin nMismatched++; $display("[TB] FAIL w1_rd_idle: got n=%0d data=%b want n=2 data=1", n, rdData1); end
      rdReq1 = 1'b0; wrReq1 = 1'b1; wrData1 = 1'b1;
      n = 0; tick(); n++;
      ext1En = 1'b0;
      while (wrAck1 !== 1'b1 && n < 30) begin tick(); n++; end
      wrReq1 = 1'b0;
      nCompared++; if (n !== 2 || oe1 !== 1'b1 || pad1 !== 1'b1) begin nMismatched++; $display("[TB] FAIL w1_wr_read: got n=%0d oe=%b pad=%b want n=2 oe=1 pad=1", n, oe1, pad1); end
      rdReq1 = 1'b1;
      n = 0; tick(); n++;
      ext1En = 1'b1; ext1Val = 1'b0;
      while (rdValid1 !== 1'b1 && n < 30) begin tick(); n++; end
      rdReq1 = 1'b0;
      nCompared++; if (n !== 3 || rdData1 !== 1'b0) begin nMismatched++; $display("[TB] FAIL w1_rd_drive: got n=%0d data=%b want n=3 data=0", n, rdData1); end
      tick();
      ext1En = 1'b0; wrReq1 = 1'b1; wrData1 = 1'b1;
      tick();
      wrReq1 = 1'b0;
      nCompared++; if (wrAck1 !== 1'b1 || pad1 !== 1'b1) begin nMismatched++; $display("[TB] FAIL w1_wr_idle: got ack=%b pad=%b want ack=1 pad=1", wrAck1, pad1); end
   endtask

   // WIDTH=32, TURN=3, SYNC=4: read IDLE 5, write READ 4, read DRIVE 8, write IDLE 1.
   task automatic test_params_w32();
      int n;
      ext32En = 1'b1; ext32Val = 32'hDEADBEEF; rdReq32 = 1'b1;
      n = 0; tick(); n++;
      while (rdValid32 !== 1'b1 && n < 30) begin tick(); n++; end
      nCompared++; if (n !== 5 || rdData32 !== 32'hDEADBEEF) begin nMismatched++; $display("[TB] FAIL w32_rd_idle: got n=%0d data=%h want n=5 data=deadbeef", n, rdData32); end
      rdReq32 = 1'b0; wrReq32 = 1'b1; wrData32 = 32'h12345678;
      n = 0; tick(); n++;
      ext32En = 1'b0;
      while (wrAck32 !== 1'b1 && n < 30) begin tick(); n++; end
      wrReq32 = 1'b0;
      nCompared++; if (n !== 4 || pad32 !== 32'h12345678) begin nMismatched++; $display("[TB] FAIL w32_wr_read: got n=%0d pad=%h want n=4 pad=12345678", n, pad32); end
      rdReq32 = 1'b1;
      n = 0; tick(); n++;
      ext32En = 1'b1; ext32Val = 32'hCAFEF00D;
      while (rdValid32 !== 1'b1 && n < 30) begin tick(); n++; end
      rdReq32 = 1'b0;
      nCompared++; if (n !== 8 || rdData32 !== 32'hCAFEF00D) begin nMismatched++; $display("[TB] FAIL w32_rd_drive: got n=%0d data=%h want n=8 data=cafef00d", n, rdData32); end
      tick();
      ext32En = 1'b0; wrReq32 = 1'b1; wrData32 = 32'h0F0F00FF;
      tick();
      wrReq32 = 1'b0;
      nCompared++; if (wrAck32 !== 1'b1 || pad32 !== 32'h0F0F00FF) begin nMismatched++; $display("[TB] FAIL w32_wr_idle: got ack=%b pad=%h want ack=1 pad=0f0f00ff", wrAck32, pad32); end
   endtask

   initial begin
      rst = 1'b1;
      wrReq = 1'b0; rdReq = 1'b0; wrData = '0; extEn = 1'b0; extVal = '0;
      wrReq1 = 1'b0; rdReq1 = 1'b0; wrData1 = 1'b0; ext1En = 1'b0; ext1Val = 1'b0;
      wrReq32 = 1'b0; rdReq32 = 1'b0; wrData32 = '0; ext32En = 1'b0; ext32Val = '0;
      test_reset();
      test_writes();
      test_write_read();
      test_read_write();
      test_simultaneous();
      test_params_w1();
      test_params_w32();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
